// File: rtl/spi_cmd_slave_if.sv
// SPI pin, command-output and transmit-handshake bundle for spi_cmd_slave.
// The slave modport is the core's view; master is the PIC/host side used by a bench.
interface spi_cmd_slave_if;
    logic        sclk;
    logic        mosi;
    logic        cs;
    logic        miso;
    logic        cmd_valid;
    logic [7:0]  opcode;
    logic [31:0] cmd_data;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic [2:0]  tx_bytes;
    logic        tx_ready;
    logic        dataReady;

    modport slave (
        input  sclk, mosi, cs, tx_valid, tx_data, tx_bytes,
        output miso, cmd_valid, opcode, cmd_data, tx_ready, dataReady
    );

    modport master (
        output sclk, mosi, cs, tx_valid, tx_data, tx_bytes,
        input  miso, cmd_valid, opcode, cmd_data, tx_ready, dataReady
    );
endinterface

// File: rtl/spi_cmd_slave.sv
// SPI mode-0 slave that assembles SUMP short/long commands from PIC bytes and
// streams queued result words back LSB byte first on miso.
module spi_cmd_slave #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           bf_clock,
    input  logic           reset_n,
    spi_cmd_slave_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StArg} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, mosi_s, cs_s;
    logic                   rise, fall, cs_fall;

    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        byte_done_q, byte_done_d;
    logic [31:0] tx_word_q, tx_word_d;
    logic [2:0]  pend_q, pend_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        miso_q, miso_d;
    logic        dready_q, dready_d;
    state_e      state_q, state_d;
    logic [1:0]  argcnt_q, argcnt_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [31:0] cmd_data_q, cmd_data_d;

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s    = cs_sync_q[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_prev_q;
    assign fall    = ~sclk_s & sclk_prev_q;
    assign cs_fall = ~cs_s & cs_prev_q;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.cs};

        rx_sh_d     = rx_sh_q;
        bitcnt_d    = bitcnt_q;
        byte_done_d = 1'b0;
        tx_word_d   = tx_word_q;
        pend_d      = pend_q;
        tx_sh_d     = tx_sh_q;
        miso_d      = tx_sh_q[7];
        dready_d    = (pend_q != 3'd0);
        state_d     = state_q;
        argcnt_d    = argcnt_q;
        cmd_valid_d = 1'b0;
        opcode_d    = opcode_q;
        cmd_data_d  = cmd_data_q;

        // cs high discards any partial byte
        if (cs_s) begin
            bitcnt_d = 3'd0;
        end else if (rise) begin
            rx_sh_d  = {rx_sh_q[6:0], mosi_s};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) byte_done_d = 1'b1;
        end

        // Acceptance and byte retirement are exclusive: one needs pend==0, the other pend!=0
        if (bus.tx_valid && (pend_q == 3'd0)) begin
            tx_word_d = bus.tx_data;
            case (bus.tx_bytes)
                3'd1, 3'd2, 3'd3: pend_d = bus.tx_bytes;
                default:          pend_d = 3'd4;
            endcase
        end else if (!cs_s && rise && (bitcnt_q == 3'd7) && (pend_q != 3'd0)) begin
            tx_word_d = tx_word_q >> 8;
            pend_d    = pend_q - 3'd1;
        end

        if (cs_fall) begin
            tx_sh_d = (pend_q != 3'd0) ? tx_word_q[7:0] : 8'h00;
        end else if (fall && (bitcnt_q != 3'd0)) begin
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
        end

        if (byte_done_q) begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_sh_q[7]) begin
                        // 0x7F is the filler the PIC clocks out while reading results
                        if (rx_sh_q != 8'h7F) begin
                            cmd_valid_d = 1'b1;
                            opcode_d    = rx_sh_q;
                            cmd_data_d  = 32'h0;
                        end
                    end else begin
                        opcode_d = rx_sh_q;
                        argcnt_d = 2'd0;
                        state_d  = StArg;
                    end
                end
                StArg: begin
                    cmd_data_d[{argcnt_q, 3'b000} +: 8] = rx_sh_q;
                    argcnt_d = argcnt_q + 2'd1;
                    if (argcnt_q == 2'd3) begin
                        cmd_valid_d = 1'b1;
                        state_d     = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge bf_clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            rx_sh_q     <= 8'h00;
            bitcnt_q    <= 3'd0;
            byte_done_q <= 1'b0;
            tx_word_q   <= 32'h0;
            pend_q      <= 3'd0;
            tx_sh_q     <= 8'h00;
            miso_q      <= 1'b0;
            dready_q    <= 1'b0;
            state_q     <= StIdle;
            argcnt_q    <= 2'd0;
            cmd_valid_q <= 1'b0;
            opcode_q    <= 8'h00;
            cmd_data_q  <= 32'h0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_sync_q   <= cs_sync_d;
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            rx_sh_q     <= rx_sh_d;
            bitcnt_q    <= bitcnt_d;
            byte_done_q <= byte_done_d;
            tx_word_q   <= tx_word_d;
            pend_q      <= pend_d;
            tx_sh_q     <= tx_sh_d;
            miso_q      <= miso_d;
            dready_q    <= dready_d;
            state_q     <= state_d;
            argcnt_q    <= argcnt_d;
            cmd_valid_q <= cmd_valid_d;
            opcode_q    <= opcode_d;
            cmd_data_q  <= cmd_data_d;
        end
    end

    assign bus.miso      = miso_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.opcode    = opcode_q;
    assign bus.cmd_data  = cmd_data_q;
    assign bus.tx_ready  = (pend_q == 3'd0);
    assign bus.dataReady = dready_q;

endmodule
